// File: rtl/program_loader.sv
// rtl/program_loader.sv - program load / run sequencer for the 8-bit processor
//
// Purpose: takes bytes from the switches one `enter` press at a time, writes
// them to consecutive RAM addresses, holds the processor in reset while
// loading, then releases it to run and parks/restarts it around `halt`.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_ni       asynchronous active-low reset
//   init_i         level; a rising edge (re)starts a load session
//   enter_i        raw push-button, asynchronous to clk_i
//   done_i         marks an enter press as end of program
//   in_i           byte from switches
//   halt_i         processor halted flag from the CU
//   mem_addr_o     RAM write address
//   mem_data_o     RAM write data
//   mem_wr_o       RAM write strobe, one cycle per byte
//   cpu_reset_n_o  active-low processor hold (0 = held)
//   load_count_o   bytes written this session (0..2^ADDR_W)
//   state_o        FSM state code for debug LEDs
module program_loader #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              init_i,
  input  logic              enter_i,
  input  logic              done_i,
  input  logic [DATA_W-1:0] in_i,
  input  logic              halt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_wr_o,
  output logic              cpu_reset_n_o,
  output logic [ADDR_W:0]   load_count_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WRITE   = 3'd2,
    S_RUN     = 3'd3,
    S_HALTED  = 3'd4,
    S_RESTART = 3'd5
  } state_e;

  // Count value meaning "RAM full": 2^ADDR_W.
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                mem_wr_q;
  logic                cpu_reset_n_q;
  logic [ADDR_W:0]     count_q;

  logic                enter_s1_q;
  logic                enter_s2_q;
  logic                enter_prev_q;
  logic                init_r_q;
  logic                init_prev_q;

  logic                press;
  logic                init_rise;
  logic [ADDR_W:0]     count_inc;

  // enter: 2-FF synchronizer plus one edge register. init is registered once
  // and then edge-detected against its own delayed copy, so both inputs are
  // only ever looked at through flops.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      enter_s1_q   <= 1'b0;
      enter_s2_q   <= 1'b0;
      enter_prev_q <= 1'b0;
      init_r_q     <= 1'b0;
      init_prev_q  <= 1'b0;
    end else begin
      enter_s1_q   <= enter_i;
      enter_s2_q   <= enter_s1_q;
      enter_prev_q <= enter_s2_q;
      init_r_q     <= init_i;
      init_prev_q  <= init_r_q;
    end
  end

  assign press     = enter_s2_q & ~enter_prev_q;
  assign init_rise = init_r_q & ~init_prev_q;
  assign count_inc = count_q + (ADDR_W+1)'(1);

  // Single FSM block; every output is a register updated alongside the state.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      mem_wr_q      <= 1'b0;
      cpu_reset_n_q <= 1'b0;
      count_q       <= '0;
    end else begin
      mem_wr_q <= 1'b0;
      if (init_rise) begin
        // Restart a session from any state; a coincident press is dropped.
        state_q       <= S_LOAD;
        addr_q        <= '0;
        count_q       <= '0;
        cpu_reset_n_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            cpu_reset_n_q <= 1'b0;
          end
          S_LOAD: begin
            if (press) begin
              if (done_i) begin
                state_q       <= S_RUN;
                cpu_reset_n_q <= 1'b1;
              end else begin
                state_q  <= S_WRITE;
                data_q   <= in_i;
                mem_wr_q <= 1'b1;
              end
            end
          end
          S_WRITE: begin
            // addr_q wraps naturally at 2^ADDR_W; count_q has one extra bit.
            addr_q  <= addr_q + ADDR_W'(1);
            count_q <= count_inc;
            if (count_inc == FULL_COUNT) begin
              state_q       <= S_RUN;
              cpu_reset_n_q <= 1'b1;
            end else begin
              state_q <= S_LOAD;
            end
          end
          S_RUN: begin
            if (halt_i) begin
              state_q <= S_HALTED;
            end
          end
          S_HALTED: begin
            if (press) begin
              state_q       <= S_RESTART;
              cpu_reset_n_q <= 1'b0;
            end
          end
          S_RESTART: begin
            state_q       <= S_RUN;
            cpu_reset_n_q <= 1'b1;
          end
          default: begin
            state_q       <= S_IDLE;
            cpu_reset_n_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_addr_o    = addr_q;
  assign mem_data_o    = data_q;
  assign mem_wr_o      = mem_wr_q;
  assign cpu_reset_n_o = cpu_reset_n_q;
  assign load_count_o  = count_q;
  assign state_o       = state_q;

endmodule
